// File: rtl/pe_slice_scheduler.sv
// Bit-slice / chunk sequencer for a 16-lane PE adder tree: walks every
// (activation slice, weight slice) pair per chunk and accumulates shifted PE sums.
module pe_slice_scheduler #(
    parameter int SLICE_BITS = 2,
    parameter int SUM_W      = 8,
    parameter int ACC_W      = 32,
    parameter int CHUNK_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          cfg_act_slices,
    input  logic [1:0]          cfg_wgt_slices,
    input  logic [CHUNK_W-1:0]  cfg_chunks,
    output logic                busy,
    output logic                issue_valid,
    output logic [1:0]          act_sel,
    output logic [1:0]          wgt_sel,
    output logic [CHUNK_W-1:0]  chunk_idx,
    input  logic [SUM_W-1:0]    pe_sum,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    result
);

    localparam int SHIFT_W = $clog2(SLICE_BITS * 6 + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           cfg_act_q, cfg_act_d;
    logic [1:0]           cfg_wgt_q, cfg_wgt_d;
    logic [CHUNK_W-1:0]   cfg_chunks_q, cfg_chunks_d;
    logic [1:0]           act_sel_q, act_sel_d;
    logic [1:0]           wgt_sel_q, wgt_sel_d;
    logic [CHUNK_W-1:0]   chunk_idx_q, chunk_idx_d;
    logic                 pipe_v_q, pipe_v_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W-1:0]     result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 issue_valid_q, issue_valid_d;
    logic                 out_valid_q, out_valid_d;
    logic                 last_issue_s;
    logic signed [ACC_W-1:0] term_s;

    assign last_issue_s = (wgt_sel_q == cfg_wgt_q) && (act_sel_q == cfg_act_q) &&
                          (chunk_idx_q == cfg_chunks_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (last_issue_s) state_d = ST_DRAIN;
                else              state_d = ST_RUN;
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
                else           state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output flags, registered from the next state so they line up with it.
    always_comb begin
        busy_d        = (state_d != ST_IDLE);
        issue_valid_d = (state_d == ST_RUN);
        out_valid_d   = (state_d == ST_DONE);
    end

    // Index walk, config capture, issue pipe and accumulation.
    always_comb begin
        cfg_act_d    = cfg_act_q;
        cfg_wgt_d    = cfg_wgt_q;
        cfg_chunks_d = cfg_chunks_q;
        act_sel_d    = act_sel_q;
        wgt_sel_d    = wgt_sel_q;
        chunk_idx_d  = chunk_idx_q;
        result_d     = result_q;
        pipe_v_d     = (state_q == ST_RUN);
        shift_d      = SHIFT_W'(SLICE_BITS) * (SHIFT_W'(act_sel_q) + SHIFT_W'(wgt_sel_q));
        term_s       = ACC_W'($signed(pe_sum)) <<< shift_q;

        // pe_sum belongs to the issue captured in the pipe one cycle earlier.
        if (pipe_v_q) acc_d = acc_q + term_s;
        else          acc_d = acc_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_act_d    = cfg_act_slices;
                    cfg_wgt_d    = cfg_wgt_slices;
                    cfg_chunks_d = cfg_chunks;
                    act_sel_d    = 2'd0;
                    wgt_sel_d    = 2'd0;
                    chunk_idx_d  = {CHUNK_W{1'b0}};
                    acc_d        = {ACC_W{1'b0}};
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_RUN: begin
                if (last_issue_s) begin
                    wgt_sel_d = wgt_sel_q;
                end else if (wgt_sel_q != cfg_wgt_q) begin
                    wgt_sel_d = wgt_sel_q + 2'd1;
                end else if (act_sel_q != cfg_act_q) begin
                    wgt_sel_d = 2'd0;
                    act_sel_d = act_sel_q + 2'd1;
                end else begin
                    wgt_sel_d   = 2'd0;
                    act_sel_d   = 2'd0;
                    chunk_idx_d = chunk_idx_q + {{(CHUNK_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DRAIN: result_d = acc_d;
            ST_DONE:  result_d = result_q;
            default:  result_d = result_q;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_act_q     <= 2'd0;
            cfg_wgt_q     <= 2'd0;
            cfg_chunks_q  <= {CHUNK_W{1'b0}};
            act_sel_q     <= 2'd0;
            wgt_sel_q     <= 2'd0;
            chunk_idx_q   <= {CHUNK_W{1'b0}};
            pipe_v_q      <= 1'b0;
            shift_q       <= {SHIFT_W{1'b0}};
            acc_q         <= {ACC_W{1'b0}};
            result_q      <= {ACC_W{1'b0}};
            busy_q        <= 1'b0;
            issue_valid_q <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            cfg_act_q     <= cfg_act_d;
            cfg_wgt_q     <= cfg_wgt_d;
            cfg_chunks_q  <= cfg_chunks_d;
            act_sel_q     <= act_sel_d;
            wgt_sel_q     <= wgt_sel_d;
            chunk_idx_q   <= chunk_idx_d;
            pipe_v_q      <= pipe_v_d;
            shift_q       <= shift_d;
            acc_q         <= acc_d;
            result_q      <= result_d;
            busy_q        <= busy_d;
            issue_valid_q <= issue_valid_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign busy        = busy_q;
    assign issue_valid = issue_valid_q;
    assign act_sel     = act_sel_q;
    assign wgt_sel     = wgt_sel_q;
    assign chunk_idx   = chunk_idx_q;
    assign out_valid   = out_valid_q;
    assign result      = result_q;

endmodule

// File: tb/tb_pe_slice_scheduler.sv
// Directed-vector bench for pe_slice_scheduler; a small responder plays the PE
// array, returning a programmed sum one cycle after each issue.
module tb_pe_slice_scheduler;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        cfg_act_slices;
    logic [1:0]        cfg_wgt_slices;
    logic [7:0]        cfg_chunks;
    logic              busy;
    logic              issue_valid;
    logic [1:0]        act_sel;
    logic [1:0]        wgt_sel;
    logic [7:0]        chunk_idx;
    logic [7:0]        pe_sum;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       result;

    int errors = 0;
    int checks = 0;

    int                pe_mode = 0;
    logic signed [7:0] pe_const = 8'sd0;
    logic signed [7:0] next_pe = 8'sd0;
    logic [11:0]       issue_q[$];

    always #5 clk = ~clk;

    pe_slice_scheduler dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_act_slices(cfg_act_slices), .cfg_wgt_slices(cfg_wgt_slices),
        .cfg_chunks(cfg_chunks), .busy(busy), .issue_valid(issue_valid),
        .act_sel(act_sel), .wgt_sel(wgt_sel), .chunk_idx(chunk_idx),
        .pe_sum(pe_sum), .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
    );

    // PE stand-in: the sum for an issue is presented during the following cycle.
    always @(negedge clk) begin
        pe_sum = next_pe;
        if (issue_valid) begin
            if (issue_q.size() < 64) issue_q.push_back({chunk_idx, act_sel, wgt_sel});
            if (pe_mode == 1) next_pe = (wgt_sel == 2'd0) ? 8'sd2 : -8'sd1;
            else              next_pe = pe_const;
        end else begin
            next_pe = 8'sd0;
        end
    end

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic start_job(input logic [1:0] a, input logic [1:0] w, input logic [7:0] c);
        issue_q.delete();
        cfg_act_slices = a;
        cfg_wgt_slices = w;
        cfg_chunks     = c;
        start          = 1'b1;
        @(negedge clk);
        start          = 1'b0;
    endtask

    // Returns cycles from the start edge to the first out_valid sample.
    task automatic wait_valid(input int budget, input bit spam, output int lat);
        lat = 1;
        while (!out_valid && lat < budget) begin
            if (spam) begin
                start          = 1'b1;
                cfg_act_slices = 2'd3;
                cfg_wgt_slices = 2'd3;
                cfg_chunks     = 8'd5;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_job(input string tag, input logic [1:0] a, input logic [1:0] w,
                           input logic [7:0] c, input logic signed [31:0] exp_res,
                           input int exp_lat);
        int lat;
        start_job(a, w, c);
        wait_valid(exp_lat + 20, 1'b0, lat);
        check_val({tag, "_latency"}, lat, exp_lat);
        check_val({tag, "_out_valid"}, {31'd0, out_valid}, 32'sd1);
        check_val({tag, "_result"}, result, exp_res);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val({tag, "_idle_busy"}, {31'd0, busy}, 32'sd0);
        check_val({tag, "_idle_out_valid"}, {31'd0, out_valid}, 32'sd0);
    endtask

    initial begin
        int lat;
        logic [11:0] exp_order [4];
        exp_order[0] = 12'h000;
        exp_order[1] = 12'h001;
        exp_order[2] = 12'h004;
        exp_order[3] = 12'h005;

        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        cfg_act_slices = 2'd0; cfg_wgt_slices = 2'd0; cfg_chunks = 8'd0;
        @(negedge clk);
        @(negedge clk);
        check_val("reset_busy", {31'd0, busy}, 32'sd0);
        check_val("reset_issue_valid", {31'd0, issue_valid}, 32'sd0);
        check_val("reset_out_valid", {31'd0, out_valid}, 32'sd0);
        check_val("reset_result", result, 32'sd0);
        rst = 1'b0;

        // Reset on the third issue of a 2x2x2 job.
        pe_mode = 0; pe_const = 8'sd1;
        start_job(2'd1, 2'd1, 8'd1);
        @(negedge clk);
        @(negedge clk);
        check_val("abort_third_issue", {20'd0, chunk_idx, act_sel, wgt_sel}, 32'sh004);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_busy", {31'd0, busy}, 32'sd0);
        check_val("abort_issue_valid", {31'd0, issue_valid}, 32'sd0);
        check_val("abort_out_valid", {31'd0, out_valid}, 32'sd0);
        check_val("abort_sel", {20'd0, chunk_idx, act_sel, wgt_sel}, 32'sd0);
        check_val("abort_result", result, 32'sd0);
        rst = 1'b0;

        pe_const = -8'sd5;
        run_job("single", 2'd0, 2'd0, 8'd0, -32'sd5, 3);
        check_val("single_issue_count", issue_q.size(), 32'sd1);
        if (issue_q.size() == 1) check_val("single_issue0", {20'd0, issue_q[0]}, 32'sd0);

        pe_const = 8'sd1;
        run_job("shift", 2'd1, 2'd1, 8'd0, 32'sd25, 6);
        check_val("shift_issue_count", issue_q.size(), 32'sd4);
        for (int i = 0; i < 4 && i < issue_q.size(); i++)
            check_val($sformatf("shift_order%0d", i), {20'd0, issue_q[i]}, {20'd0, exp_order[i]});

        // Multi-chunk with five cycles of backpressure.
        pe_mode = 1;
        start_job(2'd0, 2'd1, 8'd2);
        wait_valid(40, 1'b0, lat);
        check_val("multi_latency", lat, 32'sd8);
        check_val("multi_result", result, -32'sd6);
        check_val("multi_last_chunk", {24'd0, chunk_idx}, 32'sd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val($sformatf("hold%0d_out_valid", i), {31'd0, out_valid}, 32'sd1);
            check_val($sformatf("hold%0d_result", i), result, -32'sd6);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("multi_idle_busy", {31'd0, busy}, 32'sd0);
        check_val("multi_idle_out_valid", {31'd0, out_valid}, 32'sd0);
        check_val("multi_idle_result_kept", result, -32'sd6);

        pe_mode = 0; pe_const = 8'sd127;
        run_job("max", 2'd3, 2'd3, 8'd255, 32'sd234899200, 4098);

        // Start pulses with other cfg during RUN, DRAIN, DONE and the handshake.
        pe_const = 8'sd1;
        start_job(2'd1, 2'd1, 8'd0);
        wait_valid(40, 1'b1, lat);
        check_val("busy_start_latency", lat, 32'sd6);
        check_val("busy_start_result", result, 32'sd25);
        @(negedge clk);
        check_val("busy_start_done_held", {31'd0, out_valid}, 32'sd1);
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        check_val("busy_start_idle", {31'd0, busy}, 32'sd0);
        check_val("busy_start_issue_count", issue_q.size(), 32'sd4);

        pe_const = -8'sd5;
        run_job("after_hs", 2'd0, 2'd0, 8'd0, -32'sd5, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
